sap_ram16: RTL

- 16 x 8 program/data RAM sitting directly downstream of the memory address register; addressed by the MAR's 4-bit output.
- Two modes:
  - Run: synchronous registered read of the byte at the current MAR address, for the bus/IR stage.
  - Program: a nibble-serial loader assembles bytes from 4-bit input pairs and writes them at an auto-incrementing address, so the 8-pin dedicated input can load a full program.

---
 rtl/sap_ram16.sv | 91 +++++++++
 1 files changed

// File: rtl/sap_ram16.sv
// sap_ram16: 16x8 RAM with registered run-mode read and nibble-serial program loader
module sap_ram16 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic              rd_en,
  input  logic              prog,
  input  logic [DATA_W/2-1:0] nib_in,
  input  logic              nib_valid,
  output logic              nib_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_done,
  output logic [DATA_W-1:0] ram_out,
  output logic              ram_out_valid
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {RUN, P_HI, P_LO, P_WR} state_t;
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [ADDR_W-1:0]   prog_addr_q, prog_addr_d;
  logic [DATA_W/2-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]   ram_out_q, ram_out_d;
  logic                valid_q, valid_d, done_q, done_d;
  assign nib_ready     = (state_q == P_HI) || (state_q == P_LO);
  assign prog_addr     = prog_addr_q;
  assign prog_done     = done_q;
  assign ram_out       = ram_out_q;
  assign ram_out_valid = valid_q;
  // next-state, loader datapath and read path; prog=0 in P_HI/P_LO discards the partial byte
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    prog_addr_d = prog_addr_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    ram_out_d   = ram_out_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      RUN: begin
        if (prog) begin
          state_d     = P_HI;
          prog_addr_d = '0;
        end else if (rd_en) begin
          ram_out_d = mem_q[mar_addr];
          valid_d   = 1'b1;
        end
      end
      P_HI: begin
        state_d = !prog ? RUN : (nib_valid ? P_LO : P_HI);
        hi_d    = (prog && nib_valid) ? nib_in : hi_q;
      end
      P_LO: begin
        state_d = !prog ? RUN : (nib_valid ? P_WR : P_LO);
        lo_d    = (prog && nib_valid) ? nib_in : lo_q;
      end
      default: begin
        mem_d[prog_addr_q] = {hi_q, lo_q};
        prog_addr_d        = prog_addr_q + 1'b1;
        done_d             = (prog_addr_q == '1);
        state_d            = prog ? P_HI : RUN;
      end
    endcase
  end
  // state registers with synchronous clear of the whole array
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= RUN;
      mem_q       <= '{default: '0};
      prog_addr_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      ram_out_q   <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      prog_addr_q <= prog_addr_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      ram_out_q   <= ram_out_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end
endmodule
